// File: rtl/pipeline_pkg.sv
//------------------------------------------------------------------------------
// Module : pipeline_pkg
// Brief  : Shared types and defaults for the ID->RR skid stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  localparam int IDR_CTRL_W  = 96;
  localparam int NUM_FWD_DEF = 3;

  // Pass-through control bundle; fields sum to IDR_CTRL_W.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  alu_op;
    logic [3:0]  br_op;
    logic [3:0]  mem_op;
    logic [42:0] rsvd;
  } idr_ctrl_t;

  typedef logic [$clog2(NUM_FWD_DEF)-1:0] fwd_idx_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_idr_skid_stage_if.sv
//------------------------------------------------------------------------------
// Module : pipeline_idr_skid_stage_if
// Brief  : Handshake, payload and forwarding bundle of the ID->RR skid stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_idr_skid_stage_if #(
  parameter int XLEN    = 64,
  parameter int CTRL_W  = pipeline_pkg::IDR_CTRL_W,
  parameter int NUM_FWD = pipeline_pkg::NUM_FWD_DEF
);

  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [XLEN-1:0]                in_pc;
  logic [4:0]                     in_rs1;
  logic [4:0]                     in_rs2;
  logic [CTRL_W-1:0]              in_ctrl;
  logic [XLEN-1:0]                rf_rdata1;
  logic [XLEN-1:0]                rf_rdata2;
  logic [NUM_FWD-1:0]             fwd_valid;
  logic [NUM_FWD-1:0]             fwd_pend;
  logic [NUM_FWD-1:0][4:0]        fwd_rd;
  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [XLEN-1:0]                out_pc;
  logic [XLEN-1:0]                out_rs1_data;
  logic [XLEN-1:0]                out_rs2_data;
  logic [CTRL_W-1:0]              out_ctrl;
  logic [15:0]                    stall_cnt;

  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_ctrl,
           rf_rdata1, rf_rdata2, fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_ctrl, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_ctrl,
           rf_rdata1, rf_rdata2, fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_ctrl, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_fwd_mux.sv
//------------------------------------------------------------------------------
// Module : pipeline_fwd_mux
// Brief  : Priority operand forwarding select (index 0 wins) with hazard flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_fwd_mux #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = pipeline_pkg::NUM_FWD_DEF
) (
  input  logic [4:0]                   rs,
  input  logic [XLEN-1:0]              rf_rdata,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD-1:0]           fwd_pend,
  input  logic [NUM_FWD-1:0][4:0]      fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]              data,
  output logic                         hazard
);

  // Walk from oldest to youngest so the lowest matching index lands last.
  always_comb begin
    data   = rf_rdata;
    hazard = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i] == rs)) begin
        data   = fwd_data[i];
        hazard = fwd_pend[i];
      end
    end
    if (rs == 5'd0) begin
      data   = '0;
      hazard = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_idr_skid_stage.sv
//------------------------------------------------------------------------------
// Module : pipeline_idr_skid_stage
// Brief  : ID->RR register stage with operand forwarding and hazard stall.
//          Define IDR_SKID_BUF_EN for a 2-entry skid buffer with registered ready.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_idr_skid_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CTRL_W  = IDR_CTRL_W,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_idr_skid_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_haz;
  logic            rs2_haz;
  logic            hazard;
  logic            in_ready;
  logic            out_valid;
  logic            xfer_in;
  logic            xfer_out;
  entry_t          in_entry;
  entry_t          head;
  logic [15:0]     stall_q;

  pipeline_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs        (bus.in_rs1),
    .rf_rdata  (bus.rf_rdata1),
    .fwd_valid (bus.fwd_valid),
    .fwd_pend  (bus.fwd_pend),
    .fwd_rd    (bus.fwd_rd),
    .fwd_data  (bus.fwd_data),
    .data      (rs1_data),
    .hazard    (rs1_haz)
  );

  pipeline_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs        (bus.in_rs2),
    .rf_rdata  (bus.rf_rdata2),
    .fwd_valid (bus.fwd_valid),
    .fwd_pend  (bus.fwd_pend),
    .fwd_rd    (bus.fwd_rd),
    .fwd_data  (bus.fwd_data),
    .data      (rs2_data),
    .hazard    (rs2_haz)
  );

  assign hazard   = rs1_haz | rs2_haz;
  assign in_entry = {bus.in_pc, rs1_data, rs2_data, bus.in_ctrl};
  assign xfer_in  = bus.in_valid & in_ready;
  assign xfer_out = out_valid & bus.out_ready;

`ifdef IDR_SKID_BUF_EN
  skid_state_t state;
  entry_t      skid;
  logic        ready_q;

  // ready_q tracks (next state != TWO); it is held low through reset.
  assign in_ready  = ready_q & ~hazard;
  assign out_valid = (state != ST_EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b0;
    end else if (bus.flush) begin
      state   <= ST_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            head  <= in_entry;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (xfer_in && xfer_out) begin
            head <= in_entry;
          end else if (xfer_in) begin
            skid    <= in_entry;
            state   <= ST_TWO;
            ready_q <= 1'b0;
          end else if (xfer_out) begin
            head  <= '0;
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (xfer_out) begin
            head  <= skid;
            skid  <= '0;
            state <= ST_ONE;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_EMPTY;
          head  <= '0;
          skid  <= '0;
        end
      endcase
    end
  end
`else
  logic valid_q;
  logic ready_en;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en & (~valid_q | bus.out_ready) & ~hazard;
  assign out_valid = valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      head     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (bus.flush) begin
        valid_q <= 1'b0;
        head    <= '0;
      end else if (xfer_in) begin
        valid_q <= 1'b1;
        head    <= in_entry;
      end else if (xfer_out) begin
        valid_q <= 1'b0;
        head    <= '0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (bus.in_valid && !xfer_in && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = head.pc;
  assign bus.out_rs1_data = head.rs1_data;
  assign bus.out_rs2_data = head.rs2_data;
  assign bus.out_ctrl     = head.ctrl;
  assign bus.stall_cnt    = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_idr_skid_stage.sv
//------------------------------------------------------------------------------
// Module : tb_pipeline_idr_skid_stage
// Brief  : Self-checking bench with a queue-based reference model of the stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_idr_skid_stage;
  import pipeline_pkg::*;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 96;
  localparam int NF     = 3;
`ifdef IDR_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic        clk;
  logic        reset;
  int          tests;
  int          fails;
  ent_t        q[$];
  logic        started;
  logic [15:0] m_stall;
  logic        exp_ready;
  logic        exp_valid;
  ent_t        exp_head;
  logic        e_acc;
  logic        e_pop;
  logic        e_flush;
  logic        e_inc;
  ent_t        e_entry;

  pipeline_idr_skid_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NF)) bus ();

  pipeline_idr_skid_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Operand rule: x0 reads zero, youngest matching source wins, else regfile.
  function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return '0;
    for (int i = 0; i < NF; i++)
      if (bus.fwd_valid[i] && (bus.fwd_rd[i] == rs)) return {bus.fwd_pend[i], bus.fwd_data[i]};
    return {1'b0, rf};
  endfunction

  task automatic model_eval();
    logic [XLEN:0] r1;
    logic [XLEN:0] r2;
    r1 = resolve(bus.in_rs1, bus.rf_rdata1);
    r2 = resolve(bus.in_rs2, bus.rf_rdata2);
    exp_valid = (q.size() != 0);
    exp_head  = '0;
    if (exp_valid) exp_head = q[0];
    exp_ready = started && !r1[XLEN] && !r2[XLEN] && ((q.size() < CAP) || (!SKID && bus.out_ready));
    e_acc   = bus.in_valid && exp_ready;
    e_pop   = exp_valid && bus.out_ready;
    e_flush = bus.flush;
    e_inc   = bus.in_valid && !e_acc;
    e_entry = {bus.in_pc, r1[XLEN-1:0], r2[XLEN-1:0], bus.in_ctrl};
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_stall = '0;
      started = 1'b0;
    end else begin
      if (e_inc && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (e_flush) begin
        q.delete();
      end else begin
        if (e_pop) void'(q.pop_front());
        if (e_acc) q.push_back(e_entry);
      end
      started = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_ctrl   = '0;
    bus.rf_rdata1 = '0;
    bus.rf_rdata2 = '0;
    bus.fwd_valid = '0;
    bus.fwd_pend  = '0;
    bus.fwd_rd    = '0;
    bus.fwd_data  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    q.delete();
    m_stall = '0;
    started = 1'b0;
    advance();
    advance();
    reset = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    q.delete();
    m_stall = '0;
    started = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.in_ready); end
    tests++; if (bus.stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall: got %h expected 0", bus.stall_cnt); end
    tests++; if (bus.out_pc !== '0 || bus.out_ctrl !== '0) begin fails++; $display("FAIL reset_payload: got %h/%h expected 0", bus.out_pc, bus.out_ctrl); end
    advance();
    advance();
    reset = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL ready_after_release: got %b expected 0", bus.in_ready); end
    advance();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL ready_first_edge: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    bus.in_pc         = 64'h1000;
    bus.in_rs1        = 5'd5;
    bus.in_rs2        = 5'd0;
    bus.rf_rdata1     = 64'h11;
    bus.fwd_valid     = 3'b110;
    bus.fwd_rd[1]     = 5'd5;
    bus.fwd_rd[2]     = 5'd5;
    bus.fwd_data[1]   = 64'hAA;
    bus.fwd_data[2]   = 64'hBB;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL prio_ready: got %b expected 1", bus.in_ready); end
    advance();
    idle();
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL prio_valid: got %b expected 1", bus.out_valid); end
    tests++; if (bus.out_rs1_data !== 64'hAA) begin fails++; $display("FAIL prio_rs1: got %h expected aa", bus.out_rs1_data); end
    tests++; if (bus.out_pc !== 64'h1000) begin fails++; $display("FAIL prio_pc: got %h expected 1000", bus.out_pc); end
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    bus.in_rs1      = 5'd9;
    bus.rf_rdata1   = 64'h99;
    bus.in_rs2      = 5'd0;
    bus.rf_rdata2   = 64'h1234;
    bus.fwd_valid   = 3'b001;
    bus.fwd_rd[0]   = 5'd0;
    bus.fwd_data[0] = 64'h55;
    advance();
    idle();
    #1;
    tests++; if (bus.out_rs2_data !== 64'd0) begin fails++; $display("FAIL x0_rs2: got %h expected 0", bus.out_rs2_data); end
    tests++; if (bus.out_rs1_data !== 64'h99) begin fails++; $display("FAIL rf_rs1: got %h expected 99", bus.out_rs1_data); end
    advance();
  endtask

  task automatic test_hazard();
    do_reset();
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    bus.in_rs1      = 5'd7;
    bus.fwd_valid   = 3'b001;
    bus.fwd_rd[0]   = 5'd7;
    bus.fwd_pend[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hazard_ready c%0d: got %b expected 0", c, bus.in_ready); end
      advance();
    end
    bus.fwd_pend[0] = 1'b0;
    bus.fwd_data[0] = 64'h77;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hazard_release: got %b expected 1", bus.in_ready); end
    tests++; if (bus.stall_cnt !== 16'd2) begin fails++; $display("FAIL hazard_stall: got %0d expected 2", bus.stall_cnt); end
    advance();
    idle();
    #1;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 64'h77) begin
      fails++; $display("FAIL hazard_capture: got %b/%h expected 1/77", bus.out_valid, bus.out_rs1_data);
    end
    advance();
  endtask

  task automatic test_backpressure();
    idr_ctrl_t c1;
    idr_ctrl_t c2;
    c1 = '0; c1.rd = 5'd3; c1.imm = 32'hCAFE0001; c1.alu_op = 8'h12;
    c2 = '0; c2.rd = 5'd4; c2.imm = 32'hCAFE0002; c2.mem_op = 4'h5;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_pc = 64'h100; bus.in_ctrl = c1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_first: got %b expected 1", bus.in_ready); end
    advance();
    bus.in_pc = 64'h200; bus.in_ctrl = c2;
    #1;
    tests++; if (bus.in_ready !== SKID) begin fails++; $display("FAIL bp_second: got %b expected %b", bus.in_ready, SKID); end
    advance();
    bus.in_pc = 64'h300; bus.in_ctrl = '0;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_third: got %b expected 0", bus.in_ready); end
    advance();
    idle();
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.out_pc !== 64'h100 || bus.out_ctrl !== c1) begin fails++; $display("FAIL bp_drain1: got %h expected 100", bus.out_pc); end
    advance();
    tests++; if (bus.out_valid !== SKID || bus.out_pc !== (SKID ? 64'h200 : 64'h0)) begin
      fails++; $display("FAIL bp_drain2: got %b/%h expected %b", bus.out_valid, bus.out_pc, SKID);
    end
    tests++; if (bus.out_ctrl !== (SKID ? c2 : idr_ctrl_t'('0))) begin fails++; $display("FAIL bp_ctrl2: got %h", bus.out_ctrl); end
    advance();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_pc !== '0) begin fails++; $display("FAIL bp_empty: got %b/%h expected 0/0", bus.out_valid, bus.out_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_pc = 64'hA0;
    advance();
    bus.in_pc = 64'hB0;
    advance();
    bus.in_pc = 64'hC0;
    bus.flush = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_pre: got %b expected 1", bus.out_valid); end
    advance();
    idle();
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_pc !== '0) begin fails++; $display("FAIL flush_clear: got %b/%h expected 0/0", bus.out_valid, bus.out_pc); end
    advance();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_lost: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 20) == 0;
      bus.in_pc     = {$urandom, $urandom};
      bus.in_rs1    = 5'($urandom % 8);
      bus.in_rs2    = 5'($urandom % 8);
      bus.in_ctrl   = {$urandom, $urandom, $urandom};
      bus.rf_rdata1 = {$urandom, $urandom};
      bus.rf_rdata2 = {$urandom, $urandom};
      bus.fwd_valid = 3'($urandom);
      bus.fwd_pend  = 3'($urandom) & 3'($urandom);
      for (int i = 0; i < NF; i++) begin
        bus.fwd_rd[i]   = 5'($urandom % 8);
        bus.fwd_data[i] = {$urandom, $urandom};
      end
      #1;
      model_eval();
      tests++; if (bus.in_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.in_ready, exp_ready); end
      tests++; if (bus.out_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.out_valid, exp_valid); end
      tests++; if ({bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_ctrl} !== exp_head) begin
        fails++; $display("FAIL rnd_payload c%0d: got pc %h a %h b %h expected pc %h a %h b %h", c,
                          bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, exp_head.pc, exp_head.a, exp_head.b);
      end
      tests++; if (bus.stall_cnt !== m_stall) begin fails++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, bus.stall_cnt, m_stall); end
      advance();
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    bus.in_valid    = 1'b1;
    bus.in_rs1      = 5'd1;
    bus.fwd_valid   = 3'b100;
    bus.fwd_rd[2]   = 5'd1;
    bus.fwd_pend[2] = 1'b1;
    for (int c = 0; c < 65540; c++) advance();
    tests++; if (bus.stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stall_sat: got %h expected ffff", bus.stall_cnt); end
    idle();
    bus.flush = 1'b1;
    advance();
    bus.flush = 1'b0;
    #1;
    tests++; if (bus.stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stall_flush_keep: got %h expected ffff", bus.stall_cnt); end
  endtask

  task automatic test_async_reset();
    idle();
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'hDEAD;
    bus.in_rs1   = 5'd2;
    bus.rf_rdata1 = 64'hBEEF;
    bus.in_ctrl  = 96'h5;
    advance();
    #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL arst_loaded: got %b expected 1", bus.out_valid); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.out_rs1_data !== '0 || bus.out_ctrl !== '0) begin
      fails++; $display("FAIL arst_outputs: got %b/%h/%h expected 0", bus.out_valid, bus.out_pc, bus.out_rs1_data);
    end
    tests++; if (bus.stall_cnt !== 16'd0) begin fails++; $display("FAIL arst_stall: got %h expected 0", bus.stall_cnt); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b expected 0", bus.in_ready); end
    q.delete();
    m_stall = '0;
    started = 1'b0;
    idle();
    advance();
    reset = 1'b1;
    advance();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    started = 1'b0;
    m_stall = '0;
    test_reset();
    test_fwd_priority();
    test_x0();
    test_hazard();
    test_backpressure();
    test_flush();
    test_random();
    test_stall_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
